// File: rtl/skid_reg.sv
// skid_reg: two-entry elastic pipeline register (skid buffer).
//
// ready_o and v_o are decoded from the state flop only. This means no
// combinational path crosses from the consumer's ready to the producer's ready.
// When the consumer is always ready, the buffer passes one transfer per cycle.
//
// Optional feature (macro RVGA_SKID_STALL_CNT_EN):
//   defined   -> a 16-bit saturating counter of v_o && !ready_i cycles drives
//                stall_cnt_o. Only rst_ni clears it.
//   undefined -> no counter flops, and stall_cnt_o is tied to zero.
//
// Ports:
//   clk_i        clock, all state updates on posedge
//   rst_ni       synchronous active-low reset
//   flush_i      synchronous clear of all stored entries
//   v_i          producer data valid
//   ready_o      buffer can accept data this cycle
//   data_i       producer payload (width bits)
//   v_o          data_o holds a valid entry
//   ready_i      consumer accepts data_o this cycle
//   data_o       head entry payload (width bits)
//   stall_cnt_o  backpressure cycle count (16 bits)
module skid_reg #(
    parameter int unsigned width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             v_i,
    output logic             ready_o,
    input  logic [width-1:0] data_i,
    output logic             v_o,
    input  logic             ready_i,
    output logic [width-1:0] data_o,
    output logic [15:0]      stall_cnt_o
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [width-1:0]   main_q, main_d;
    logic [width-1:0]   skid_q, skid_d;
    logic               enq_c, deq_c;

    // Handshake decode, from state flops only.
    assign v_o     = (state_q != EMPTY);
    assign ready_o = (state_q != FULL);
    assign data_o  = main_q;
    assign enq_c   = v_i && ready_o;
    assign deq_c   = v_o && ready_i;

    // Next-state and data-path steering.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // Flush drops any concurrent enqueue. The data registers are left untouched.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (enq_c) begin
                        state_d = ONE;
                        main_d  = data_i;
                    end
                end
                ONE: begin
                    if (enq_c && deq_c) begin
                        main_d = data_i;
                    end else if (enq_c) begin
                        state_d = FULL;
                        skid_d  = data_i;
                    end else if (deq_c) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (deq_c) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef RVGA_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating backpressure counter. Flush does not clear it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (v_o && !ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = CNT_W'(0);
`endif

endmodule
